// File: rtl/util_mw_clken_gen.sv
// Purpose: NUM_CH phase-aligned clock-enable strobes on clk, each with a runtime integer divide ratio.
// Latency: strobe after D enabled edges from a restart; ce_out registered, align_out is combinational from registers.
// Backpressure: none; strobe/config block only. enable stalls counters, sync/div_load restart them.
module util_mw_clken_gen #(
  parameter int          NUM_CH     = 4,
  parameter int          DIV_WIDTH  = 16,
  parameter int unsigned RESET_DIV  = 1,
  parameter string       CLKIN_FREQ = "100.0"
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic                          sync,
  input  logic                          div_load,
  input  logic [NUM_CH*DIV_WIDTH-1:0]   div_in,
  output logic [NUM_CH-1:0]             ce_out,
  output logic                          align_out,
  output logic [NUM_CH*DIV_WIDTH-1:0]   div_active
);

  // CLKIN_FREQ is documentation only: it records the clk frequency the
  // ratios were chosen for and never reaches the logic.

  localparam logic [DIV_WIDTH-1:0] RESET_DIV_W = DIV_WIDTH'(RESET_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE_W       = DIV_WIDTH'(1);

  // Per-channel phase counters; each stays within 0..D-1.
  logic [DIV_WIDTH-1:0] cnt      [NUM_CH];
  // Per-channel view of the applied ratio and its terminal count.
  logic [DIV_WIDTH-1:0] div_ch   [NUM_CH];
  logic [DIV_WIDTH-1:0] term_cnt [NUM_CH];
  logic                 ch_on    [NUM_CH];

  // Slice the packed ratio register into channels and precompute D-1.
  // Comparing against D-1 before incrementing means the maximum ratio
  // never needs a counter value beyond the register width.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      div_ch[i]   = div_active[i*DIV_WIDTH +: DIV_WIDTH];
      term_cnt[i] = div_ch[i] - ONE_W;
      ch_on[i]    = (div_ch[i] != '0);
    end
  end

  // Active ratio register: reloads from div_in on request, regardless of enable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_active <= {NUM_CH{RESET_DIV_W}};
    end else if (div_load) begin
      div_active <= div_in;
    end
  end

  // Counters and strobes. A reload or sync restarts every channel; a
  // ratio of zero parks the channel; enable low freezes the phase but
  // still drops the strobe so no enable pulse leaks through a pause.
  // resetn is expected to be released synchronously to clk upstream.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
      ce_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (div_load || sync) begin
          cnt[i]    <= '0;
          ce_out[i] <= 1'b0;
        end else if (!ch_on[i]) begin
          cnt[i]    <= '0;
          ce_out[i] <= 1'b0;
        end else if (!enable) begin
          ce_out[i] <= 1'b0;
        end else if (cnt[i] == term_cnt[i]) begin
          cnt[i]    <= '0;
          ce_out[i] <= 1'b1;
        end else begin
          cnt[i]    <= cnt[i] + ONE_W;
          ce_out[i] <= 1'b0;
        end
      end
    end
  end

  // Alignment: every active channel strobing together; never high with no
  // active channel.
  always_comb begin
    logic any_on;
    logic all_ce;
    any_on = 1'b0;
    all_ce = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_on[i]) begin
        any_on = 1'b1;
        if (!ce_out[i]) begin
          all_ce = 1'b0;
        end
      end
    end
    align_out = any_on & all_ce;
  end

endmodule

// File: tb/tb_util_mw_clken_gen.sv
// Purpose: self-checking bench for util_mw_clken_gen (4 channels, 16-bit ratios, RESET_DIV=1).
// Latency: checks 1 ns after each rising edge; inputs change only at that point.
// Backpressure: none; directed table, hand sequences, then random run against a model.
module tb_util_mw_clken_gen;

  localparam int NCH = 4;
  localparam int DW  = 16;

  logic              clk;
  logic              resetn;
  logic              enable;
  logic              sync;
  logic              div_load;
  logic [NCH*DW-1:0] div_in;
  logic [NCH-1:0]    ce_out;
  logic              align_out;
  logic [NCH*DW-1:0] div_active;

  util_mw_clken_gen #(
    .NUM_CH(NCH), .DIV_WIDTH(DW), .RESET_DIV(1), .CLKIN_FREQ("100.0")
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .sync(sync),
    .div_load(div_load), .div_in(div_in), .ce_out(ce_out),
    .align_out(align_out), .div_active(div_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: each channel counts enabled edges since its last
  // restart; a strobe is due whenever that count is a multiple of the ratio.
  int unsigned m_div [NCH];
  longint      m_e   [NCH];
  logic [NCH-1:0] m_ce;

  function automatic logic m_align();
    logic any_on = 1'b0;
    logic all_ce = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (m_div[c] != 0) begin
        any_on = 1'b1;
        if (!m_ce[c]) all_ce = 1'b0;
      end
    end
    return any_on && all_ce;
  endfunction

  function automatic logic [NCH*DW-1:0] m_divs();
    logic [NCH*DW-1:0] v = '0;
    for (int c = 0; c < NCH; c++) v[c*DW +: DW] = m_div[c][DW-1:0];
    return v;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_div[c] = 1;
      m_e[c]   = 0;
    end
    m_ce = '0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model alongside the DUT edge.
  task automatic step(input bit en, input bit sy, input bit ld, input logic [NCH*DW-1:0] din);
    enable   = en;
    sync     = sy;
    div_load = ld;
    div_in   = din;
    @(posedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (ld) begin
        m_div[c] = int'(din[c*DW +: DW]);
        m_e[c]   = 0;
        m_ce[c]  = 1'b0;
      end else if (sy || m_div[c] == 0) begin
        m_e[c]  = 0;
        m_ce[c] = 1'b0;
      end else if (!en) begin
        m_ce[c] = 1'b0;
      end else begin
        m_e[c]  = m_e[c] + 1;
        m_ce[c] = ((m_e[c] % longint'(m_div[c])) == 0);
      end
    end
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".ce"},    64'(ce_out),     64'(m_ce));
    chk({tag, ".align"}, 64'(align_out),  64'(m_align()));
    chk({tag, ".div"},   64'(div_active), 64'(m_divs()));
  endtask

  typedef struct {
    bit                en;
    bit                sy;
    bit                ld;
    logic [NCH*DW-1:0] din;
    logic [NCH-1:0]    exp_ce;
    logic              exp_al;
    logic [NCH*DW-1:0] exp_div;
  } vec_t;

  localparam logic [63:0] R_MIX = 64'h0000_0004_0003_0002;
  localparam logic [63:0] R_TWO = 64'h0002_0002_0002_0002;
  localparam logic [63:0] R_ONE = 64'h0001_0001_0001_0001;

  vec_t vecs [18];

  initial begin
    // Ratios {2,3,4,0}: strobes at multiples of each ratio, all together at 12.
    vecs[0]  = '{1'b1, 1'b0, 1'b1, R_MIX, 4'b0000, 1'b0, R_MIX};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, '0,    4'b0000, 1'b0, R_MIX};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, '0,    4'b0001, 1'b0, R_MIX};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, '0,    4'b0010, 1'b0, R_MIX};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, '0,    4'b0101, 1'b0, R_MIX};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, '0,    4'b0000, 1'b0, R_MIX};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, '0,    4'b0011, 1'b0, R_MIX};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, '0,    4'b0000, 1'b0, R_MIX};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, '0,    4'b0101, 1'b0, R_MIX};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, '0,    4'b0010, 1'b0, R_MIX};
    vecs[10] = '{1'b1, 1'b0, 1'b0, '0,    4'b0001, 1'b0, R_MIX};
    vecs[11] = '{1'b1, 1'b0, 1'b0, '0,    4'b0000, 1'b0, R_MIX};
    vecs[12] = '{1'b1, 1'b0, 1'b0, '0,    4'b0111, 1'b1, R_MIX};
    // sync together with div_load behaves as div_load alone.
    vecs[13] = '{1'b1, 1'b1, 1'b1, R_TWO, 4'b0000, 1'b0, R_TWO};
    vecs[14] = '{1'b1, 1'b0, 1'b0, '0,    4'b0000, 1'b0, R_TWO};
    vecs[15] = '{1'b1, 1'b0, 1'b0, '0,    4'b1111, 1'b1, R_TWO};
    vecs[16] = '{1'b1, 1'b0, 1'b0, '0,    4'b0000, 1'b0, R_TWO};
    vecs[17] = '{1'b1, 1'b0, 1'b0, '0,    4'b1111, 1'b1, R_TWO};

    m_reset();
    resetn   = 1'b0;
    enable   = 1'b1;
    sync     = 1'b0;
    div_load = 1'b0;
    div_in   = '0;

    // Reset state.
    #23;
    chk("rst.ce",    64'(ce_out),     64'h0);
    chk("rst.align", 64'(align_out),  64'h0);
    chk("rst.div",   64'(div_active), R_ONE);

    // Release away from the edge; ratio 1 strobes on every edge.
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step(1'b1, 1'b0, 1'b0, '0);
    chk("rel.ce0",    64'(ce_out),    64'hf);
    chk("rel.align0", 64'(align_out), 64'h1);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("rel.ce1",    64'(ce_out),    64'hf);

    // Table.
    for (int v = 0; v < 18; v++) begin
      step(vecs[v].en, vecs[v].sy, vecs[v].ld, vecs[v].din);
      chk($sformatf("vec%0d.ce", v),    64'(ce_out),     64'(vecs[v].exp_ce));
      chk($sformatf("vec%0d.align", v), 64'(align_out),  64'(vecs[v].exp_al));
      chk($sformatf("vec%0d.div", v),   64'(div_active), vecs[v].exp_div);
    end

    // Ratio 5, pause at cnt=3 for 7 cycles, strobe 2 enabled edges after resume.
    step(1'b1, 1'b0, 1'b1, 64'h0005_0005_0005_0005);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      chk("pre_gap.ce", 64'(ce_out), 64'h0);
    end
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b0, 1'b0, '0);
      chk("gap.ce", 64'(ce_out), 64'h0);
    end
    step(1'b1, 1'b0, 1'b0, '0);
    chk("resume1.ce", 64'(ce_out), 64'h0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("resume2.ce", 64'(ce_out), 64'hf);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      chk($sformatf("period5.%0d", k), 64'(ce_out), (k == 5) ? 64'hf : 64'h0);
    end

    // Ratio 3, sync at cnt=1: all channels strobe together 3 cycles later.
    step(1'b1, 1'b0, 1'b1, 64'h0003_0003_0003_0003);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("sync.ce", 64'(ce_out), 64'h0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      chk($sformatf("sync%0d.ce", k),    64'(ce_out),    (k % 3 == 0) ? 64'hf : 64'h0);
      chk($sformatf("sync%0d.align", k), 64'(align_out), (k % 3 == 0) ? 64'h1 : 64'h0);
    end

    // Ratio 7: reset dropped while strobing clears outputs without waiting for an edge.
    step(1'b1, 1'b0, 1'b1, 64'h0007_0007_0007_0007);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 1'b0, '0);
    chk("r7.ce", 64'(ce_out), 64'hf);
    #2;
    resetn = 1'b0;
    m_reset();
    #1;
    chk("arst.ce",    64'(ce_out),     64'h0);
    chk("arst.align", 64'(align_out),  64'h0);
    chk("arst.div",   64'(div_active), R_ONE);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step(1'b1, 1'b0, 1'b0, '0);
    chk("rerel.ce",  64'(ce_out),     64'hf);
    chk("rerel.div", 64'(div_active), R_ONE);

    // Random run against the model.
    for (int n = 0; n < 400; n++) begin
      logic [NCH*DW-1:0] din;
      bit en, sy, ld;
      for (int c = 0; c < NCH; c++) begin
        din[c*DW +: DW] = ($urandom_range(0, 40) == 0) ? 16'hffff : 16'($urandom_range(0, 6));
      end
      en = ($urandom_range(0, 7) != 0);
      sy = ($urandom_range(0, 24) == 0);
      ld = ($urandom_range(0, 19) == 0);
      step(en, sy, ld, din);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
